// File: rtl/reg_bank_pkg.sv
// ============================================================================
//  Module      : reg_bank_pkg
//  Description : Shared constants and types for the reg_bank_mp register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_bank_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_DEPTH  = 16;
    localparam int REG_ADDR_W = $clog2(REG_DEPTH);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;

endpackage : reg_bank_pkg

`default_nettype wire

// File: rtl/reg_bank_rdport.sv
// ============================================================================
//  Module      : reg_bank_rdport
//  Description : One registered read port: storage mux, write-first bypass
//                compare and output register that holds while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [DATA_W-1:0]            rd_data_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (rd_en_i) begin
            // Write-first: a same-cycle write to the read address wins.
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                data_d = wr_data_i;
            end else begin
                data_d = mem_i[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data_o = data_q;

endmodule : reg_bank_rdport

`default_nettype wire

// File: rtl/reg_bank_mp.sv
// ============================================================================
//  Module      : reg_bank_mp
//  Description : Parametrised register bank, one write port, two registered
//                read ports with bypass. Define REG_BANK_ZERO_R0_EN to make
//                register 0 read as constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter  int DATA_W = REG_DATA_W,
    parameter  int DEPTH  = REG_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic [DEPTH-1:0]  written
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0]             written_q;
    logic [DEPTH-1:0]             written_d;
    logic                         rd_valid_q;
    logic                         wr_eff;

    // Masking the strobe also kills the bypass path for address 0.
    always_comb begin
`ifdef REG_BANK_ZERO_R0_EN
        wr_eff = wr_en && (wr_addr != '0);
`else
        wr_eff = wr_en;
`endif
        written_d = written_q;
        if (wr_eff) begin
            written_d[wr_addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else if (wr_eff && (wr_addr == ADDR_W'(i))) begin
                mem_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            written_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            written_q  <= written_d;
            rd_valid_q <= rd_en;
        end
    end

    reg_bank_rdport #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport_a (
        .clk       (clk),
        .rst_i     (reset),
        .mem_i     (mem_q),
        .wr_en_i   (wr_eff),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_a),
        .rd_data_o (rd_data_a)
    );

    reg_bank_rdport #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rdport_b (
        .clk       (clk),
        .rst_i     (reset),
        .mem_i     (mem_q),
        .wr_en_i   (wr_eff),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr_b),
        .rd_data_o (rd_data_b)
    );

    assign rd_valid = rd_valid_q;
    assign written  = written_q;

endmodule : reg_bank_mp

`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
// ============================================================================
//  Module      : tb_reg_bank_mp
//  Description : Scoreboard bench for reg_bank_mp (16x16 and 8x4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_mp;

`ifdef REG_BANK_ZERO_R0_EN
    localparam bit ZERO_R0 = 1'b1;
`else
    localparam bit ZERO_R0 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_valid;
    logic [15:0] written;

    logic        s_reset = 1'b1;
    logic        s_wr_en = 1'b0;
    logic [1:0]  s_wr_addr = '0;
    logic [7:0]  s_wr_data = '0;
    logic        s_rd_en = 1'b0;
    logic [1:0]  s_rd_addr_a = '0;
    logic [1:0]  s_rd_addr_b = '0;
    logic [7:0]  s_rd_data_a;
    logic [7:0]  s_rd_data_b;
    logic        s_rd_valid;
    logic [3:0]  s_written;

    always #5 clk = ~clk;

    reg_bank_mp dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid), .written(written)
    );

    reg_bank_mp #(.DATA_W(8), .DEPTH(4)) dut_s (
        .clk(clk), .reset(s_reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
        .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .rd_valid(s_rd_valid), .written(s_written)
    );

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] w;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          started = 1'b0;

    // Reference model: register contents as a plain array.
    logic [15:0] m_mem[16];
    logic [15:0] m_wr = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] ra, input logic we,
                                               input logic [3:0] wa, input logic [15:0] wd);
        if (ZERO_R0 && ra == 4'd0) return 16'h0;
        if (we && wa == ra) return wd;
        return m_mem[ra];
    endfunction

    // Drive one cycle's inputs and push the state expected after that edge.
    task automatic cyc(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(negedge clk);
        reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
        if (r) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_wr = '0; m_a = '0; m_b = '0;
            e.v = 1'b0;
        end else begin
            if (re) begin
                m_a = model_read(ra, we, wa, wd);
                m_b = model_read(rb, we, wa, wd);
            end
            e.v = re;
            if (we && !(ZERO_R0 && wa == 4'd0)) begin
                m_mem[wa] = wd;
                m_wr[wa]  = 1'b1;
            end
        end
        e.a = m_a; e.b = m_b; e.w = m_wr;
        q.push_back(e);
        started = 1'b1;
    endtask

    // Monitor: data/written compared every cycle; data only popped once per edge.
    always @(posedge clk) begin
        if (started) begin
            exp_t e;
            #1;
            if (q.size() == 0) begin
                chk("queue_underflow", 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                chk("rd_valid", {15'd0, rd_valid}, {15'd0, e.v});
                chk("written", written, e.w);
                if (rd_valid) begin
                    chk("rd_data_a", rd_data_a, e.a);
                    chk("rd_data_b", rd_data_b, e.b);
                end else begin
                    chk("hold_a", rd_data_a, e.a);
                    chk("hold_b", rd_data_b, e.b);
                end
            end
        end
    end

    task automatic s_cyc(input logic r, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic re, input logic [1:0] ra, input logic [1:0] rb);
        @(negedge clk);
        s_reset = r; s_wr_en = we; s_wr_addr = wa; s_wr_data = wd;
        s_rd_en = re; s_rd_addr_a = ra; s_rd_addr_b = rb;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wa;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 4'(i), 4'(15 - i));

        cyc(0, 1, 4'd0, 16'hFFFF, 0, 0, 0);
        cyc(0, 1, 4'd15, 16'h1234, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd0, 4'd15);

        cyc(0, 1, 4'd5, 16'hBEEF, 1, 4'd5, 4'd6);

        cyc(0, 0, 0, 0, 1, 4'd5, 4'd15);
        cyc(0, 1, 4'd5, 16'h5555, 0, 4'd5, 4'd15);
        cyc(0, 1, 4'd15, 16'hAAAA, 0, 4'd5, 4'd15);
        cyc(0, 1, 4'd5, 16'h0F0F, 0, 4'd5, 4'd15);

        cyc(0, 1, 4'd3, 16'h00AA, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4'd3, 4'd3);
        cyc(0, 0, 0, 0, 1, 4'd3, 4'd3);
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            wa = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, wa, 16'($urandom),
                $urandom_range(0, 2) != 0,
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        started = 1'b0;
        chk("queue_drained", 16'(q.size()), 16'd0);

        // 8-bit x 4-entry instance.
        s_cyc(1, 0, 0, 0, 0, 0, 0);
        s_cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) s_cyc(0, 1, 2'(i), 8'(8'h11 * (i + 1)), 0, 0, 0);
        s_cyc(0, 0, 0, 0, 1, 2'd0, 2'd3);
        @(posedge clk); #1;
        chk("s_valid0", {15'd0, s_rd_valid}, 16'd1);
        chk("s_a0", {8'd0, s_rd_data_a}, ZERO_R0 ? 16'h0000 : 16'h0011);
        chk("s_b3", {8'd0, s_rd_data_b}, 16'h0044);
        chk("s_written", {12'd0, s_written}, ZERO_R0 ? 16'h000E : 16'h000F);
        s_cyc(0, 0, 0, 0, 1, 2'd1, 2'd2);
        @(posedge clk); #1;
        chk("s_valid1", {15'd0, s_rd_valid}, 16'd1);
        chk("s_a1", {8'd0, s_rd_data_a}, 16'h0022);
        chk("s_b2", {8'd0, s_rd_data_b}, 16'h0033);
        s_cyc(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("s_valid_idle", {15'd0, s_rd_valid}, 16'd0);
        chk("s_hold_a", {8'd0, s_rd_data_a}, 16'h0022);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_bank_mp

`default_nettype wire

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised successor to the 16x16 one-hot-enabled register bank feeding the CPU datapath.
- Address-decoded write port, two registered read ports (A/B) with write-to-read bypass, and a per-register "written" mask for debug and bench checks.
- Sits between the ALU result bus and the ALU operand muxes.

Parameters:
- DATA_W, 16, register width in bits.
- DEPTH, 16, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data (ALU bus).
- rd_en  in  1  read strobe, both ports.
- rd_addr_a  in  ADDR_W  port A index.
- rd_addr_b  in  ADDR_W  port B index.
- rd_data_a  out  DATA_W  registered port A data.
- rd_data_b  out  DATA_W  registered port B data.
- rd_valid  out  1  rd_data_* updated this cycle.
- written  out  DEPTH  bit i set once register i has been written since reset.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled on the rising clk edge while reset=1.
- On reset:
  - all registers, rd_data_a and rd_data_b go to 0;
  - rd_valid goes to 0; written goes to all-zero;
  - a concurrent wr_en or rd_en is ignored.
- Write: wr_en=1 at an edge stores wr_data into reg[wr_addr] and sets written[wr_addr]. The new value is visible in storage the following cycle.
- Read:
  - rd_en=1 at edge N loads rd_data_a/b from reg[rd_addr_a/b]; rd_valid=1 in cycle N+1 (1-cycle latency).
  - rd_en=0: rd_data_a/b hold their previous values; rd_valid=0 next cycle.
- Bypass: if wr_en and rd_en are both 1 in the same cycle and rd_addr_x == wr_addr, rd_data_x takes wr_data (write-first). Applies independently per port; both ports may bypass together.
- Both read ports may address the same register; both return the same value.
- No state machine beyond the storage: the read pipeline is one stage, and rd_valid is rd_en delayed one cycle, cleared by reset.
- Addresses are always in range (DEPTH a power of two). No wrap or error handling needed.
- Reset mid-stream: a read issued in the reset cycle produces rd_valid=0 and zero data next cycle. A write in the reset cycle is lost.
- written bits never clear except on reset.

Optional Feature:
- Macro REG_BANK_ZERO_R0_EN.
- Defined:
  - reg[0] is hard-wired to 0; writes to address 0 are discarded;
  - written[0] stays 0;
  - reads of address 0 return 0, including during bypass.
- Undefined: reg[0] is an ordinary register.

Decomposition:
- Shared package reg_bank_pkg:
  - constants REG_DATA_W=16, REG_DEPTH=16;
  - typedef reg_addr_t (ADDR_W bits);
  - typedef reg_word_t (DATA_W bits).
- One sub-module, reg_bank_rdport: one read mux plus bypass compare plus output register. It is instantiated twice (A, B).
- Storage, write decode and the written mask stay in the top module.

Test Plan:
- Reset: hold reset=1 for 2 edges, then read every address -> all data 0, written=16'h0000, rd_valid pulses 1 cycle after each rd_en.
- Basic write/read: write 16'hFFFF to r0 and 16'h1234 to r15; next cycle rd_addr_a=0, rd_addr_b=15, rd_en=1 -> next cycle rd_data_a=FFFF, rd_data_b=1234, written=16'h8001. Under REG_BANK_ZERO_R0_EN: rd_data_a=0, written=16'h8000.
- Bypass: same cycle, wr_en=1, wr_addr=5, wr_data=16'hBEEF, rd_en=1, rd_addr_a=5, rd_addr_b=6 (r6=0) -> rd_data_a=BEEF, rd_data_b=0.
- Hold: after a valid read, drop rd_en for 3 cycles while writing to the read addresses -> rd_data_a/b unchanged, rd_valid=0.
- Reset mid-operation: write r3=16'h00AA, then assert reset in the same cycle as rd_en with rd_addr_a=3 -> next cycle rd_data_a=0, rd_valid=0; a later read of r3 returns 0 and written[3]=0.
- Parametrisation: instantiate DATA_W=8, DEPTH=4; write addresses 0..3 with 8'h11..8'h44, dual-read (0,3) and (1,2) -> 11/44 then 22/33, written=4'hF.
